// File: rtl/rapid_pkg.sv
// Shared widths and the pipeline controller state type.
package rapid_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2,
    FLUSH    = 2'd3
  } pctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Combinational load-use detector: the ID instruction reads a register the EX load writes.
module pipeline_hazard_detect
  import rapid_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_is_load,
  output logic                  o_load_use
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_match = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);

  // x0 is never written, so a load to it cannot create a dependency.
  assign o_load_use = i_ex_is_load && (i_ex_rd != '0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory and mul/div waits, branch squash, load-use bubbles,
// plus a saturating count of fetch-stall cycles.
module pipeline_ctrl
  import rapid_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_is_load,
  input  logic                  i_branch_taken,
  input  logic                  i_mdu_start,
  input  logic                  i_mdu_done,
  input  logic                  i_dmem_req,
  input  logic                  i_dmem_ack,
  output logic                  o_if_enable,
  output logic                  o_id_enable,
  output logic                  o_ex_enable,
  output logic                  o_pc_load,
  output logic                  o_id_flush,
  output logic                  o_ex_bubble,
  output logic [XLEN-1:0]       o_stall_cycles
);

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

  pctrl_state_t    r_state;
  pctrl_state_t    w_state_d;
  logic [2:0]      r_flush_cnt;
  logic [2:0]      w_flush_cnt_d;
  logic [XLEN-1:0] r_stall_cnt;
  logic            w_load_use;
  logic            w_if_en;
  logic            w_id_en;
  logic            w_ex_en;
  logic            w_pc_load;
  logic            w_id_flush;
  logic            w_ex_bubble;

  pipeline_hazard_detect u_hazard (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_uses_rs1 (i_id_uses_rs1),
    .i_id_uses_rs2 (i_id_uses_rs2),
    .i_ex_rd       (i_ex_rd),
    .i_ex_is_load  (i_ex_is_load),
    .o_load_use    (w_load_use)
  );

  always_comb begin
    w_if_en       = 1'b1;
    w_id_en       = 1'b1;
    w_ex_en       = 1'b1;
    w_pc_load     = 1'b0;
    w_id_flush    = 1'b0;
    w_ex_bubble   = 1'b0;
    w_state_d     = r_state;
    w_flush_cnt_d = r_flush_cnt;
    // Reset overrides everything so outputs read as a free-running pipeline.
    if (!i_reset) begin
      unique case (r_state)
        RUN: begin
          if (i_dmem_req && !i_dmem_ack) begin
            {w_if_en, w_id_en, w_ex_en} = 3'b000;
            w_state_d = MEM_WAIT;
          end else if (i_mdu_start) begin
            {w_if_en, w_id_en, w_ex_en} = 3'b000;
            w_state_d = MDU_WAIT;
          end else if (i_branch_taken) begin
            w_pc_load   = 1'b1;
            w_id_flush  = 1'b1;
            w_ex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_state_d     = FLUSH;
              w_flush_cnt_d = FlushInit;
            end
          end else if (w_load_use) begin
            w_if_en     = 1'b0;
            w_id_en     = 1'b0;
            w_ex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (i_dmem_ack) begin
            w_state_d = RUN;
          end else begin
            {w_if_en, w_id_en, w_ex_en} = 3'b000;
          end
        end
        MDU_WAIT: begin
          if (i_mdu_done) begin
            w_state_d = RUN;
          end else begin
            {w_if_en, w_id_en, w_ex_en} = 3'b000;
          end
        end
        FLUSH: begin
          w_id_flush    = 1'b1;
          w_ex_bubble   = 1'b1;
          w_flush_cnt_d = r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) begin
            w_state_d = RUN;
          end
        end
        default: w_state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_flush_cnt <= w_flush_cnt_d;
      if (!w_if_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign o_if_enable    = w_if_en;
  assign o_id_enable    = w_id_en;
  assign o_ex_enable    = w_ex_en;
  assign o_pc_load      = w_pc_load;
  assign o_id_flush     = w_id_flush;
  assign o_ex_bubble    = w_ex_bubble;
  assign o_stall_cycles = i_reset ? '0 : r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: per-cycle comparison against a behavioural model plus directed literals.
module tb_pipeline_ctrl;

  localparam int unsigned FC = 2;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        u1, u2, ex_load, br, mdu_start, mdu_done, dreq, dack;
  logic        if_en, id_en, ex_en, pc_load, id_flush, ex_bubble;
  logic [31:0] stall;

  int n_pass  = 0;
  int n_total = 0;

  pipeline_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_id_rs1       (rs1),
    .i_id_rs2       (rs2),
    .i_id_uses_rs1  (u1),
    .i_id_uses_rs2  (u2),
    .i_ex_rd        (ex_rd),
    .i_ex_is_load   (ex_load),
    .i_branch_taken (br),
    .i_mdu_start    (mdu_start),
    .i_mdu_done     (mdu_done),
    .i_dmem_req     (dreq),
    .i_dmem_ack     (dack),
    .o_if_enable    (if_en),
    .o_id_enable    (id_en),
    .o_ex_enable    (ex_en),
    .o_pc_load      (pc_load),
    .o_id_flush     (id_flush),
    .o_ex_bubble    (ex_bubble),
    .o_stall_cycles (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Model: what the pipeline is currently waiting for and how many squash cycles remain.
  bit     m_mem_wait, m_mdu_wait;
  int     m_flush_left;
  longint m_stall;

  typedef struct packed {bit ife; bit ide; bit exe; bit pcl; bit idf; bit exb;} exp_t;

  function automatic bit load_use();
    return ex_load && ex_rd != 0 && ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
  endfunction

  function automatic exp_t expect_now();
    exp_t e = '{ife: 1, ide: 1, exe: 1, pcl: 0, idf: 0, exb: 0};
    if (rst) return e;
    if (m_mem_wait) begin
      if (!dack) {e.ife, e.ide, e.exe} = 3'b000;
    end else if (m_mdu_wait) begin
      if (!mdu_done) {e.ife, e.ide, e.exe} = 3'b000;
    end else if (m_flush_left > 0) begin
      e.idf = 1; e.exb = 1;
    end else if (dreq && !dack) begin
      {e.ife, e.ide, e.exe} = 3'b000;
    end else if (mdu_start) begin
      {e.ife, e.ide, e.exe} = 3'b000;
    end else if (br) begin
      e.pcl = 1; e.idf = 1; e.exb = 1;
    end else if (load_use()) begin
      e.ife = 0; e.ide = 0; e.exb = 1;
    end
    return e;
  endfunction

  initial begin
    m_mem_wait = 0; m_mdu_wait = 0; m_flush_left = 0; m_stall = 0;
  end

  always @(posedge clk) begin
    exp_t e;
    e = expect_now();
    if (rst) begin
      m_mem_wait = 0; m_mdu_wait = 0; m_flush_left = 0; m_stall = 0;
    end else begin
      if (!e.ife && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_mem_wait) begin
        if (dack) m_mem_wait = 0;
      end else if (m_mdu_wait) begin
        if (mdu_done) m_mdu_wait = 0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (dreq && !dack) begin
        m_mem_wait = 1;
      end else if (mdu_start) begin
        m_mdu_wait = 1;
      end else if (br) begin
        m_flush_left = FC - 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = expect_now();
    check("if_enable", if_en, e.ife);
    check("id_enable", id_en, e.ide);
    check("ex_enable", ex_en, e.exe);
    check("pc_load", pc_load, e.pcl);
    check("id_flush", id_flush, e.idf);
    check("ex_bubble", ex_bubble, e.exb);
    check("stall_cycles", stall, rst ? 0 : m_stall);
  end

  task automatic idle();
    rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; ex_rd = 0; ex_load = 0;
    br = 0; mdu_start = 0; mdu_done = 0; dreq = 0; dack = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; idle();
    next_cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1; idle();
    next_cycle();
    next_cycle();
    mid();
    check("reset if_enable", if_en, 1);
    check("reset pc_load", pc_load, 0);
    check("reset stall", stall, 0);
    next_cycle();
    rst = 0;

    // Load-use on rs1, then the same with rd = x0.
    ex_load = 1; ex_rd = 5; rs1 = 5; u1 = 1;
    mid();
    check("lu if_enable", if_en, 0);
    check("lu id_enable", id_en, 0);
    check("lu ex_enable", ex_en, 1);
    check("lu ex_bubble", ex_bubble, 1);
    next_cycle();
    ex_rd = 0; rs1 = 0;
    mid();
    check("lu x0 if_enable", if_en, 1);
    check("lu stall", stall, 1);
    next_cycle();
    idle(); ex_load = 1; ex_rd = 7; rs2 = 7; u2 = 0;
    mid();
    check("rs2 unused if_enable", if_en, 1);
    next_cycle();

    // Branch with a second branch inside the squash window.
    idle(); br = 1;
    mid();
    check("br c0 pc_load", pc_load, 1);
    check("br c0 id_flush", id_flush, 1);
    next_cycle();
    mid();
    check("br c1 pc_load", pc_load, 0);
    check("br c1 id_flush", id_flush, 1);
    next_cycle();
    br = 0;
    mid();
    check("br c2 id_flush", id_flush, 0);
    check("br c2 if_enable", if_en, 1);
    next_cycle();

    // Data memory wait of three cycles.
    do_reset();
    dreq = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("dmem wait if_enable", if_en, 0);
      next_cycle();
    end
    dack = 1;
    mid();
    check("dmem ack ex_enable", ex_en, 1);
    next_cycle();
    idle();
    mid();
    check("dmem stall", stall, 3);
    dreq = 1; dack = 1;
    mid();
    next_cycle();
    idle();
    mid();
    check("dmem zero-wait stall", stall, 3);
    next_cycle();

    // MDU start beats a simultaneous branch.
    mdu_start = 1; br = 1;
    mid();
    check("mdu pc_load", pc_load, 0);
    check("mdu if_enable", if_en, 0);
    next_cycle();
    mdu_start = 0;
    repeat (3) next_cycle();
    br = 0; mdu_done = 1;
    mid();
    check("mdu done if_enable", if_en, 1);
    next_cycle();
    idle();
    mid();
    check("mdu after pc_load", pc_load, 0);
    check("mdu stall", stall, 7);
    next_cycle();

    // Reset in the middle of a memory wait.
    dreq = 1;
    next_cycle();
    rst = 1;
    mid();
    check("rst mid if_enable", if_en, 1);
    next_cycle();
    rst = 0; idle();
    mid();
    check("after rst if_enable", if_en, 1);
    check("after rst stall", stall, 0);
    next_cycle();

    // Memory wait outranks mdu start and branch.
    dreq = 1; mdu_start = 1; br = 1;
    mid();
    check("prio pc_load", pc_load, 0);
    next_cycle();
    idle(); dack = 1;
    next_cycle();
    idle();

    // Random traffic checked only by the model.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      rs1       = 5'($urandom_range(0, 3));
      rs2       = 5'($urandom_range(0, 3));
      ex_rd     = 5'($urandom_range(0, 3));
      u1        = 1'($urandom_range(0, 1));
      u2        = 1'($urandom_range(0, 1));
      ex_load   = 1'($urandom_range(0, 1));
      br        = ($urandom_range(0, 4) == 0);
      mdu_start = ($urandom_range(0, 7) == 0);
      mdu_done  = ($urandom_range(0, 2) == 0);
      dreq      = ($urandom_range(0, 5) == 0);
      dack      = ($urandom_range(0, 2) == 0);
      next_cycle();
    end
    rst = 0; idle();
    mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, 2, number of cycles of wrong-path squash after a taken branch (legal range 1..7).
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_id_rs1, i_id_rs2  in  5 each  source register addresses of the instruction in ID.
REQ-005 i_id_uses_rs1, i_id_uses_rs2  in  1 each  the ID instruction reads rs1 / rs2.
REQ-006 i_ex_rd  in  5  destination register of the instruction in EX; i_ex_is_load  in  1  the EX instruction is a load.
REQ-007 i_branch_taken  in  1  EX resolved a taken branch or jump (redirect).
REQ-008 i_mdu_start  in  1  EX issues a multi-cycle mul/div; i_mdu_done  in  1  mul/div result ready.
REQ-009 i_dmem_req  in  1  MEM stage data access pending; i_dmem_ack  in  1  data memory completes the access.
REQ-010 o_if_enable, o_id_enable, o_ex_enable  out  1 each  pipeline_enable to the IF, ID (decoder_state) and EX stage registers.
REQ-011 o_pc_load  out  1  redirect the PC; o_id_flush  out  1  drives pc_load/flush of the ID register (loads NOP).
REQ-012 o_ex_bubble  out  1  EX register loads a NOP instead of the ID output.
REQ-013 o_stall_cycles  out  XLEN  saturating count of cycles with o_if_enable = 0.

Function
REQ-014 FSM states SHALL be RUN, MEM_WAIT, MDU_WAIT, FLUSH; outputs combinational from state and inputs, state and counters registered.
REQ-015 In RUN, events SHALL be prioritised: memory wait > mdu start > branch taken > load-use hazard > normal.
REQ-016 RUN, i_dmem_req=1 and i_dmem_ack=0: all three enables 0, next state MEM_WAIT.
REQ-017 RUN, i_mdu_start=1 (no memory wait): all enables 0, next state MDU_WAIT.
REQ-018 RUN, i_branch_taken=1: enables 1, o_pc_load=1, o_id_flush=1, o_ex_bubble=1; if FLUSH_CYCLES>1 next state FLUSH with counter = FLUSH_CYCLES-1, else stay RUN.
REQ-019 Load-use hazard = i_ex_is_load and i_ex_rd!=0 and ((i_id_uses_rs1 and rs1==rd) or (i_id_uses_rs2 and rs2==rd)); in RUN it SHALL give o_if_enable=0, o_id_enable=0, o_ex_enable=1, o_ex_bubble=1, stay RUN.
REQ-020 RUN with no event: all enables 1, o_pc_load/o_id_flush/o_ex_bubble 0.
REQ-021 MEM_WAIT: enables 0 while i_dmem_ack=0; in the ack cycle enables 1 and next state RUN; all other inputs ignored.
REQ-022 MDU_WAIT: enables 0 while i_mdu_done=0; in the done cycle enables 1 and next state RUN; all other inputs ignored.
REQ-023 FLUSH: enables 1, o_id_flush=1, o_ex_bubble=1, o_pc_load=0; counter decrements each cycle, RUN after the cycle where counter=1; i_branch_taken, i_mdu_start, i_dmem_req and hazards ignored (wrong path).
REQ-024 dmem ack in the same cycle as request (i_dmem_req=1, i_dmem_ack=1) SHALL be zero-wait: no stall, normal RUN priority continues.
REQ-025 o_stall_cycles SHALL increment by 1 on every clock where o_if_enable=0 and saturate at all-ones.
REQ-026 o_pc_load SHALL be high for exactly one cycle per accepted redirect.

Reset
REQ-027 i_reset=1 at a rising edge SHALL force state RUN, flush counter 0, o_stall_cycles 0, overriding any in-progress wait or flush.
REQ-028 While i_reset is high, outputs SHALL read: enables 1, o_pc_load 0, o_id_flush 0, o_ex_bubble 0, o_stall_cycles 0.

Structure
REQ-029 rapid_pkg SHALL hold XLEN, REG_ADDR_W=5 and typedef enum pctrl_state_t {RUN, MEM_WAIT, MDU_WAIT, FLUSH}.
REQ-030 Load-use comparison SHALL live in combinational sub-module pipeline_hazard_detect; FSM, flush counter and stall counter stay in pipeline_ctrl.

Verification
REQ-031 ex load rd=5, id rs1=5 uses_rs1=1 -> one cycle if/id enable 0, ex_bubble 1, stall_cycles=1; rd=0 same case -> no stall.
REQ-032 branch_taken 1 cycle, FLUSH_CYCLES=2 -> cycle0 pc_load=1 flush=1, cycle1 flush=1 pc_load=0, cycle2 normal.
REQ-033 dmem_req=1, ack after 3 cycles -> enables 0 for 3 cycles, 1 in ack cycle, stall_cycles=3.
REQ-034 mdu_start and branch_taken same cycle -> MDU_WAIT taken, no pc_load; done after 4 cycles -> RUN.
REQ-035 reset asserted mid MEM_WAIT -> next cycle RUN, enables 1, stall_cycles 0.
REQ-036 branch_taken asserted again during FLUSH -> ignored, no second pc_load pulse.
